syndrome_calc: RTL and testbench



---
 rtl/bch_pkg.sv | 53 +++++
 rtl/gf_mul_alpha_const.sv | 23 ++
 rtl/syndrome_calc.sv | 132 +++++++++++++
 tb/tb_syndrome_calc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared BCH definitions: code select encodings, field sizes, code lengths,
// primitive polynomials, syndrome FSM states and a multiply-by-alpha helper.
package bch_pkg;

    typedef enum logic [1:0] {
        CODE_63   = 2'b00,
        CODE_255  = 2'b01,
        CODE_1023 = 2'b10,
        CODE_RSVD = 2'b11
    } code_t;

    localparam int unsigned M_63   = 6;
    localparam int unsigned M_255  = 8;
    localparam int unsigned M_1023 = 10;
    localparam int unsigned M_MAX  = 10;

    localparam int unsigned N_63   = 63;
    localparam int unsigned N_255  = 255;
    localparam int unsigned N_1023 = 1023;

    // Full polynomials including the x^m term
    localparam logic [10:0] POLY_63   = 11'h043;
    localparam logic [10:0] POLY_255  = 11'h11D;
    localparam logic [10:0] POLY_1023 = 11'h409;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Multiply a field element by alpha; operands are LSB-aligned in M_MAX bits
    function automatic logic [M_MAX-1:0] gf_mul_alpha(code_t code, logic [M_MAX-1:0] a);
        logic [M_MAX-1:0] y;
        case (code)
            CODE_63:  y = {4'b0, a[4:0], 1'b0} ^ (a[5] ? {4'b0, POLY_63[5:0]} : 10'd0);
            CODE_255: y = {2'b0, a[6:0], 1'b0} ^ (a[7] ? {2'b0, POLY_255[7:0]} : 10'd0);
            default:  y = {a[8:0], 1'b0} ^ (a[9] ? POLY_1023[9:0] : 10'd0);
        endcase
        return y;
    endfunction

    function automatic logic [9:0] last_idx(code_t code);
        logic [9:0] n;
        case (code)
            CODE_63:  n = 10'(N_63 - 1);
            CODE_255: n = 10'(N_255 - 1);
            default:  n = 10'(N_1023 - 1);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/gf_mul_alpha_const.sv
// Combinational multiply by the constant alpha^J in the field chosen by i_code.
module gf_mul_alpha_const
    import bch_pkg::*;
#(
    parameter int J = 1
) (
    input  code_t            i_code,
    input  logic [M_MAX-1:0] i_a,
    output logic [M_MAX-1:0] o_y
);

    logic [M_MAX-1:0] acc;

    always_comb begin
        acc = i_a;
        for (int k = 0; k < J; k++) begin
            acc = gf_mul_alpha(i_code, acc);
        end
    end

    assign o_y = acc;

endmodule

// File: rtl/syndrome_calc.sv
// Serial BCH syndrome calculator (Horner's rule, one hard bit per cycle).
// Optional macro SYND_ZERO_FLAG_EN builds the all-syndromes-zero flag on o_zero.
module syndrome_calc
    import bch_pkg::*;
#(
    parameter int NUM_SYND = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_code,
    input  logic       i_start,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    output logic       o_busy,
    output logic [9:0] o_S1,
    output logic [9:0] o_S2,
    output logic [9:0] o_S3,
    output logic [9:0] o_S4,
    output logic [9:0] o_S5,
    output logic [9:0] o_S6,
    output logic [9:0] o_S7,
    output logic [9:0] o_S8,
    output logic       o_valid,
    output logic       o_zero,
    output logic [1:0] o_dbg_state
);

    // i_bit_valid has no ready: a bit is taken on every cycle it is high while
    // in ACCUM, or alongside an accepted i_start (then it is r(n-1)).

    state_t     state_q, state_d;
    code_t      code_q, code_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] synd_q [8];
    logic [9:0] synd_d [8];
    logic [9:0] mul_out [8];
    logic       start_ok;
    logic       wide_en;

    assign start_ok = i_start && (code_t'(i_code) != CODE_RSVD);
    assign wide_en  = (code_q == CODE_1023);

    for (genvar g = 0; g < 8; g++) begin : g_synd
        if (g < NUM_SYND) begin : g_on
            gf_mul_alpha_const #(.J(g + 1)) u_mul (
                .i_code (code_q),
                .i_a    (synd_q[g]),
                .o_y    (mul_out[g])
            );
        end else begin : g_off
            assign mul_out[g] = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        synd_d  = synd_q;
        if (start_ok) begin
            state_d = ST_ACCUM;
            code_d  = code_t'(i_code);
            cnt_d   = i_bit_valid ? 10'd1 : 10'd0;
            // Cleared registers make the first Horner step just the bit itself
            for (int j = 0; j < 8; j++) begin
                synd_d[j] = (j < NUM_SYND) ? {9'b0, i_bit_valid & i_bit} : 10'd0;
            end
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (i_bit_valid) begin
                        for (int j = 0; j < 8; j++) begin
                            if (j < NUM_SYND) synd_d[j] = mul_out[j] ^ {9'b0, i_bit};
                        end
                        if (cnt_q == last_idx(code_q)) begin
                            state_d = ST_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= CODE_63;
            cnt_q   <= '0;
            for (int j = 0; j < 8; j++) synd_q[j] <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            for (int j = 0; j < 8; j++) synd_q[j] <= synd_d[j];
        end
    end

    assign o_busy      = (state_q == ST_ACCUM);
    assign o_valid     = (state_q == ST_DONE);
    assign o_dbg_state = state_q;

    assign o_S1 = synd_q[0];
    assign o_S2 = synd_q[1];
    assign o_S3 = synd_q[2];
    assign o_S4 = synd_q[3];
    // The short codes only define S1..S4
    assign o_S5 = wide_en ? synd_q[4] : 10'd0;
    assign o_S6 = wide_en ? synd_q[5] : 10'd0;
    assign o_S7 = wide_en ? synd_q[6] : 10'd0;
    assign o_S8 = wide_en ? synd_q[7] : 10'd0;

`ifdef SYND_ZERO_FLAG_EN
    logic all_zero;

    always_comb begin
        all_zero = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if ((j < 4 || wide_en) && synd_q[j] != 10'd0) all_zero = 1'b0;
        end
    end

    assign o_zero = o_valid && all_zero;
`else
    assign o_zero = 1'b0;
`endif

endmodule

// File: tb/tb_syndrome_calc.sv
// Self-checking bench for syndrome_calc: random received words evaluated against
// a power-table polynomial evaluation model, plus directed boundary words.
module tb_syndrome_calc;

    localparam int W = 81;  // {zero, S8 .. S1}
`ifdef SYND_ZERO_FLAG_EN
    localparam logic ZF_ON = 1'b1;
`else
    localparam logic ZF_ON = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [1:0] i_code;
    logic       i_start, i_bit, i_bit_valid;
    logic       o_busy, o_valid, o_zero;
    logic [9:0] o_S1, o_S2, o_S3, o_S4, o_S5, o_S6, o_S7, o_S8;
    logic [1:0] o_dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int n_valid_seen = 0;
    int n_words_exp = 0;
    logic [W-1:0] exp_q[$];
    logic rbits [1023];  // transmit order: rbits[0] is r(n-1)

    syndrome_calc #(.NUM_SYND(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_code      (i_code),
        .i_start     (i_start),
        .i_bit       (i_bit),
        .i_bit_valid (i_bit_valid),
        .o_busy      (o_busy),
        .o_S1        (o_S1),
        .o_S2        (o_S2),
        .o_S3        (o_S3),
        .o_S4        (o_S4),
        .o_S5        (o_S5),
        .o_S6        (o_S6),
        .o_S7        (o_S7),
        .o_S8        (o_S8),
        .o_valid     (o_valid),
        .o_zero      (o_zero),
        .o_dbg_state (o_dbg_state)
    );

    // clock
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: S_j = r(alpha^j) = XOR of alpha^(j*deg) over the set coefficients
    function automatic logic [W-1:0] model(input logic [1:0] code);
        int m, n, poly, v;
        int pw[1023];
        logic [9:0] s;
        logic [W-1:0] r;
        logic z;
        case (code)
            2'd0:    begin m = 6;  n = 63;   poly = 'h43;  end
            2'd1:    begin m = 8;  n = 255;  poly = 'h11d; end
            default: begin m = 10; n = 1023; poly = 'h409; end
        endcase
        v = 1;
        for (int e = 0; e < n; e++) begin
            pw[e] = v;
            v = v << 1;
            if ((v & (1 << m)) != 0) v = v ^ poly;
        end
        r = '0;
        z = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            s = '0;
            if (code == 2'd2 || j <= 4) begin
                for (int k = 0; k < n; k++) begin
                    if (rbits[k]) s = s ^ 10'(pw[(j * (n - 1 - k)) % n]);
                end
            end
            if (s != 0) z = 1'b0;
            r[(j-1)*10 +: 10] = s;
        end
        r[80] = z & ZF_ON;
        return r;
    endfunction

    // scoreboard
    always @(negedge i_clk) begin : mon
        logic [W-1:0] e, act;
        if (i_rst_n && o_valid) begin
            n_valid_seen++;
            act = {o_zero, o_S8, o_S7, o_S6, o_S5, o_S4, o_S3, o_S2, o_S1};
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                for (int j = 0; j < 8; j++) begin
                    check($sformatf("S%0d", j + 1), 32'(act[j*10 +: 10]), 32'(e[j*10 +: 10]));
                end
                check("zero_flag", 32'(act[80]), 32'(e[80]));
            end
        end
    end

    task automatic fill_zero();
        for (int k = 0; k < 1023; k++) rbits[k] = 1'b0;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 1023; k++) rbits[k] = 1'($urandom_range(1));
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_zero"}, 32'(o_zero), 32'd0);
        check({tag, "_state"}, 32'(o_dbg_state), 32'd0);
        check({tag, "_S1"}, 32'(o_S1), 32'd0);
        check({tag, "_S4"}, 32'(o_S4), 32'd0);
        check({tag, "_S8"}, 32'(o_S8), 32'd0);
    endtask

    task automatic idle(input int cycles, input bit noise);
        for (int c = 0; c < cycles; c++) begin
            i_bit_valid = noise;
            i_bit = 1'($urandom_range(1));
            @(posedge i_clk); #1;
        end
        i_bit_valid = 1'b0;
    endtask

    // Entered and left #1 after a rising edge. rst_at >= 0 pulses reset after
    // that many accepted bits; n_send < n leaves the word unfinished.
    task automatic send_word(input logic [1:0] code, input int n_send, input int bub_pct,
                             input bit bit_on_start, input int rst_at);
        int n;
        int k;
        n = (code == 2'd0) ? 63 : (code == 2'd1) ? 255 : 1023;
        k = 0;
        if (n_send == n && rst_at < 0) begin
            exp_q.push_back(model(code));
            n_words_exp++;
        end
        i_start = 1'b1;
        i_code  = code;
        if (bit_on_start) begin
            i_bit_valid = 1'b1;
            i_bit = rbits[0];
            k = 1;
        end else begin
            i_bit_valid = 1'b0;
        end
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 32'd1);
        while (k < n_send) begin
            if (k == rst_at) begin
                i_bit_valid = 1'b0;
                i_rst_n = 1'b0;
                #1;
                check_all_clear("midword_rst");
                @(posedge i_clk); #1;
                i_rst_n = 1'b1;
                return;
            end
            if ($urandom_range(99) < bub_pct) begin
                i_bit_valid = 1'b0;
                i_bit = 1'($urandom_range(1));
            end else begin
                i_bit_valid = 1'b1;
                i_bit = rbits[k];
                k++;
            end
            @(posedge i_clk); #1;
        end
        i_bit_valid = 1'b0;
        if (n_send == n) begin
            check("valid_latency", 32'(o_valid), 32'd1);
            check("busy_in_done", 32'(o_busy), 32'd0);
        end
    endtask

    initial begin
        int code;
        i_rst_n = 1'b0;
        i_code = 2'd0;
        i_start = 1'b0;
        i_bit = 1'b0;
        i_bit_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_all_clear("reset");
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // reserved code and stray bits in IDLE are ignored
        i_start = 1'b1; i_code = 2'd3; i_bit_valid = 1'b1; i_bit = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        idle(2, 1'b1);
        check("rsvd_ignored_busy", 32'(o_busy), 32'd0);
        check("rsvd_ignored_S1", 32'(o_S1), 32'd0);

        // all-zero 1023 word
        fill_zero();
        send_word(2'd2, 1023, 0, 1'b1, -1);
        check("allzero_zero", 32'(o_zero), 32'(ZF_ON));
        check("allzero_S8", 32'(o_S8), 32'd0);

        // only r0 set
        fill_zero();
        rbits[1022] = 1'b1;
        send_word(2'd2, 1023, 0, 1'b1, -1);
        check("r0_S1", 32'(o_S1), 32'h001);
        check("r0_S8", 32'(o_S8), 32'h001);
        check("r0_zero", 32'(o_zero), 32'd0);

        // only r1022 set
        fill_zero();
        rbits[0] = 1'b1;
        send_word(2'd2, 1023, 10, 1'b1, -1);
        check("r1022_S1", 32'(o_S1), 32'h204);

        // GF(2^6): only r62 set
        fill_zero();
        rbits[0] = 1'b1;
        send_word(2'd0, 63, 0, 1'b1, -1);
        check("c00_S1", 32'(o_S1), 32'h21);
        check("c00_S2", 32'(o_S2), 32'h31);
        check("c00_S5", 32'(o_S5), 32'd0);
        idle(4, 1'b1);
        check("hold_S1", 32'(o_S1), 32'h21);
        check("hold_busy", 32'(o_busy), 32'd0);

        // abort after 100 bits, then a clean all-zero 255 word
        fill_rand();
        send_word(2'd1, 100, 20, 1'b1, -1);
        fill_zero();
        send_word(2'd1, 255, 10, 1'b1, -1);
        idle(2, 1'b0);

        // random words, back-to-back starts in DONE, with and without a bit on start
        for (int w = 0; w < 6; w++) begin
            code = $urandom_range(2);
            fill_rand();
            send_word(2'(code), (code == 0) ? 63 : (code == 1) ? 255 : 1023,
                      $urandom_range(30), 1'($urandom_range(1)), -1);
        end
        idle(3, 1'b0);

        // reset at bit 500, then a clean word
        fill_rand();
        send_word(2'd2, 1023, 25, 1'b1, 500);
        idle(5, 1'b1);
        check_all_clear("post_rst");
        fill_rand();
        send_word(2'd2, 1023, 20, 1'b1, -1);
        idle(4, 1'b0);

        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("valid_count", 32'(n_valid_seen), 32'(n_words_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
